// File: rtl/reg_file_wb.sv
// reg_file_wb: 32-entry register file with a one-entry write staging register.
// Writes are captured into staging on one edge and committed to the array on the
// next. All three read ports forward from staging, so a write is visible right
// after its own edge. WriteData has no path to the read ports, so the
// ALU -> WriteData -> ReadData loop stays broken.
//
// Ports:
//   CLK        system clock, rising edge
//   Reset      asynchronous active-low reset
//   RegWre     write enable for the current write-back
//   WriteReg   destination index (writes to index 0 are dropped)
//   WriteData  write-back value
//   ReadReg1/2 operand indices -> ReadData1/2 (combinational)
//   DbgReg     observation index -> DbgData (combinational)
//   WrCount    committed-write count, saturates at 16'hFFFF
module reg_file_wb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              RegWre,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic [ADDR_W-1:0] DbgReg,
   output logic [DATA_W-1:0] DbgData,
   output logic [15:0]       WrCount
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = 16;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              stg_v_q,    stg_v_d;
   logic [ADDR_W-1:0] stg_addr_q, stg_addr_d;
   logic [DATA_W-1:0] stg_data_q, stg_data_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;

   // Staging capture and saturating commit counter.
   always_comb begin
      stg_v_d    = 1'b0;
      stg_addr_d = stg_addr_q;
      stg_data_d = stg_data_q;
      wr_count_d = wr_count_q;
      if (RegWre && (WriteReg != '0)) begin
         stg_v_d    = 1'b1;
         stg_addr_d = WriteReg;
         stg_data_d = WriteData;
      end
      if (stg_v_q && (wr_count_q != {CNT_W{1'b1}})) begin
         wr_count_d = wr_count_q + CNT_W'(1);
      end
   end

   // Staging and counter state.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         stg_v_q    <= 1'b0;
         stg_addr_q <= '0;
         stg_data_q <= '0;
         wr_count_q <= '0;
      end else begin
         stg_v_q    <= stg_v_d;
         stg_addr_q <= stg_addr_d;
         stg_data_q <= stg_data_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Array commit from staging; a staged write is lost if reset hits first.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (stg_v_q) begin
         mem_q[stg_addr_q] <= stg_data_q;
      end
   end

   // Read resolution: index 0, then staging, then array.
   function automatic logic [DATA_W-1:0] resolve(input logic [ADDR_W-1:0] idx);
      logic [DATA_W-1:0] val;
      if (idx == '0) begin
         val = '0;
      end else if (stg_v_q && (idx == stg_addr_q)) begin
         val = stg_data_q;
      end else begin
         val = mem_q[idx];
      end
      return val;
   endfunction

   assign ReadData1 = resolve(ReadReg1);
   assign ReadData2 = resolve(ReadReg2);
   assign DbgData   = resolve(DbgReg);
   assign WrCount   = wr_count_q;

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32-entry general-purpose register file for the single-cycle datapath.
- Sources both ALU operands (ReadData1, ReadData2) and sinks the write-back value (ALU result or memory data) selected upstream.
- Writes pass through a one-entry staging register before committing to the array, which isolates write-back timing from the array.
- Reads forward from the staging register, so software sees normal register semantics.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- RegWre  input  1  write enable for the current write-back
- WriteReg  input  ADDR_W  destination register index
- WriteData  input  DATA_W  write-back value
- ReadReg1  input  ADDR_W  operand-1 index (rs)
- ReadReg2  input  ADDR_W  operand-2 index (rt)
- ReadData1  output  DATA_W  operand-1 value, combinational
- ReadData2  output  DATA_W  operand-2 value, combinational
- DbgReg  input  ADDR_W  debug/observation read index
- DbgData  output  DATA_W  debug read value, combinational
- WrCount  output  16  number of committed writes, saturating

Behaviour:
- Interface: one clock (CLK); Reset is asynchronous and active-low.
- Reset low, applied at any time:
  - all array entries = 0
  - staging valid = 0, addr = 0, data = 0
  - WrCount = 0
  - so ReadData1, ReadData2 and DbgData read 0
  - a staged write in flight is dropped, not committed
- State:
  - array[0..2**ADDR_W-1]
  - stg_v, stg_addr, stg_data
  - WrCount
- Rising CLK, Reset high, all in parallel:
  - Commit: if stg_v, then array[stg_addr] <= stg_data and WrCount increments; WrCount holds at 16'hFFFF once reached.
  - Capture: if RegWre=1 and WriteReg!=0, then stg_v <= 1, stg_addr <= WriteReg, stg_data <= WriteData; otherwise stg_v <= 0.
- Writes to index 0 are discarded: never staged, never counted.
- Read resolution, identical for all three read ports, in priority order:
  - index 0 -> 0
  - stg_v and index==stg_addr -> stg_data
  - otherwise array[index]
- No same-cycle bypass of WriteData to the read ports. WriteData depends on the ALU result, which depends on ReadData, so a bypass would form a combinational loop. This is forbidden by design.
- Latency: a write presented at edge N is visible on the read ports immediately after edge N (via staging). It is in the array after edge N+1.
- Back-to-back writes to the same register (edges N and N+1):
  - at N+1 the older value commits and the newer value is staged
  - reads return the newer value after N+1
  - the array holds the newer value after N+2
- Back-to-back writes to different registers: both visible after their respective edges; no loss.
- RegWre=0 cycle after a write: the staged entry commits; stg_v clears; the read returns the array value, which is the same data.
- Reset released between edges: the first rising edge with Reset high behaves as a normal cycle with stg_v=0.
- No X propagation: every output is driven from reset onward; index inputs are always in range by width.

Test Plan:
- Reset low mid-run with a pending write (RegWre=1, WriteReg=5, WriteData=32'h1234_5678 captured, then Reset low before the next edge) -> ReadData1 at index 5 = 0, WrCount=0; after release, reg 5 still reads 0.
- Write reg 3 = 32'hDEAD_BEEF at edge N, RegWre=0 afterwards -> ReadReg1=3 gives DEAD_BEEF right after edge N; DbgReg=3 gives DEAD_BEEF after N+1; WrCount=1 after N+1.
- Write reg 0 = 32'hFFFF_FFFF -> ReadData1/2 at index 0 = 0 on every cycle; WrCount unchanged.
- Writes to reg 7 of 1, then 2, then 3 on consecutive edges -> reads give 1, 2, 3 after each edge; array value of reg 7 = 3 after a final idle edge; WrCount=3.
- ReadReg1=ReadReg2=9 while RegWre=1, WriteReg=9, WriteData=32'hA5A5_A5A5 in the same cycle -> both read the old value (0) until the edge, then A5A5_A5A5; no combinational path from WriteData.
- 70000 consecutive writes to reg 1 -> WrCount saturates and holds at 16'hFFFF.
